// File: rtl/vip_pkg.sv
// Shared constants, types and helpers for the Sobel edge-detection stage.
package vip_pkg;

    localparam logic [1:0] MODE_GREY = 2'd0;
    localparam logic [1:0] MODE_MAG  = 2'd1;
    localparam logic [1:0] MODE_BIN  = 2'd2;
    localparam logic [1:0] MODE_INV  = 2'd3;

    localparam int LAT = 5;

    localparam logic [15:0] LUMA_R = 16'd77;
    localparam logic [15:0] LUMA_G = 16'd150;
    localparam logic [15:0] LUMA_B = 16'd29;

    localparam logic [10:0] SAT_MAX = 11'd255;

    typedef enum logic {WAIT_SYNC, ACTIVE} state_t;

    // Per-pixel side data that travels alongside the window arithmetic.
    typedef struct packed {
        logic [7:0] luma;
        logic       ovf;
        logic       border;
        logic [1:0] mode;
        logic [7:0] thresh;
    } pix_meta_t;

    // Coefficients sum to 256, so the 16-bit sum cannot overflow.
    function automatic logic [7:0] luma8(input logic [15:0] p);
        logic [7:0]  r8, g8, b8;
        logic [15:0] s;
        r8 = {p[15:11], p[15:13]};
        g8 = {p[10:5], p[10:9]};
        b8 = {p[4:0], p[4:2]};
        s  = LUMA_R * 16'(r8) + LUMA_G * 16'(g8) + LUMA_B * 16'(b8);
        return s[15:8];
    endfunction

    function automatic logic [15:0] grey565(input logic [7:0] g);
        return {g[7:3], g[7:2], g[7:3]};
    endfunction

endpackage

// File: rtl/vip_line_buf.sv
// Two chained line buffers: lb1 receives the row that lb0 held before this write.
module vip_line_buf #(
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [7:0]    wdata,
    output logic [7:0]    rd0,
    output logic [7:0]    rd1
);

    logic [7:0] mem0 [DEPTH];
    logic [7:0] mem1 [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            rd0        <= mem0[addr];
            rd1        <= mem1[addr];
            mem0[addr] <= wdata;
            mem1[addr] <= mem0[addr];
        end
    end

endmodule

// File: rtl/vip_sobel_stage.sv
// RGB565 -> luma -> 3x3 causal window -> |Gx|+|Gy|, with frame sync delayed to match.
module vip_sobel_stage
    import vip_pkg::*;
#(
    parameter int H_MAX = 2048,
    parameter int X_W   = 11,
    parameter int PIX_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cfg_mode,
    input  logic [7:0]       cfg_thresh,
    input  logic             pre_frame_vsync,
    input  logic             pre_frame_href,
    input  logic             pre_frame_de,
    input  logic [PIX_W-1:0] pre_rgb,
    output logic             post_frame_vsync,
    output logic             post_frame_href,
    output logic             post_frame_de,
    output logic [PIX_W-1:0] post_rgb,
    output logic [X_W-1:0]   line_len,
    output logic             err_overflow
);

    localparam int             AW    = (H_MAX > 1) ? $clog2(H_MAX) : 1;
    localparam logic [X_W:0]   H_LIM = (X_W+1)'(H_MAX);
    localparam logic [X_W-1:0] X_SAT = '1;

    state_t             state_q, state_d;
    logic               vs_d, hs_d, vs_rise, hs_fall, de_in, ovf_in;
    logic [X_W-1:0]     x_q, y_q, x_cur, y_cur, x1;
    logic [1:0]         mode_sh;
    logic [7:0]         thr_sh;
    pix_meta_t          meta_in;
    pix_meta_t          meta_pipe [1:4];
    logic [LAT:1]       vld_pipe, vs_pipe, hs_pipe;
    logic [7:0]         rd0, rd1;
    logic [2:0][2:0][7:0] win;
    logic [9:0]         sx_p, sx_n, sy_p, sy_n;
    logic signed [10:0] gx, gy;
    logic [10:0]        ax, ay, mag;
    logic [7:0]         m8;
    logic [PIX_W-1:0]   rgb_c;

    // Frame start takes effect for a pixel arriving on the same clock.
    always_comb begin
        vs_rise = pre_frame_vsync & ~vs_d;
        hs_fall = hs_d & ~pre_frame_href;
        de_in   = pre_frame_de & ((state_q == ACTIVE) | vs_rise);
        x_cur   = vs_rise ? '0 : x_q;
        y_cur   = vs_rise ? '0 : y_q;
        ovf_in  = de_in & ({1'b0, x_cur} >= H_LIM);
        meta_in        = '0;
        meta_in.luma   = luma8(pre_rgb);
        meta_in.ovf    = ovf_in;
        meta_in.border = (x_cur < X_W'(2)) | (y_cur < X_W'(2));
        meta_in.mode   = vs_rise ? cfg_mode : mode_sh;
        meta_in.thresh = vs_rise ? cfg_thresh : thr_sh;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == WAIT_SYNC && vs_rise)
            state_d = ACTIVE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_SYNC;
            vs_d         <= 1'b0;
            hs_d         <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            mode_sh      <= MODE_GREY;
            thr_sh       <= '0;
            line_len     <= '0;
            err_overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_d    <= pre_frame_vsync;
            hs_d    <= pre_frame_href;
            if (vs_rise) begin
                mode_sh <= cfg_mode;
                thr_sh  <= cfg_thresh;
            end
            if (de_in)
                x_q <= (x_cur == X_SAT) ? x_cur : x_cur + X_W'(1);
            else if (vs_rise || hs_fall)
                x_q <= '0;
            if (vs_rise)
                y_q <= '0;
            else if (hs_fall && x_q != '0 && y_q != X_SAT)
                y_q <= y_q + X_W'(1);
            if (hs_fall && x_q != '0)
                line_len <= x_q;
            if (ovf_in)
                err_overflow <= 1'b1;
            else if (vs_rise)
                err_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            vs_pipe  <= '0;
            hs_pipe  <= '0;
            x1       <= '0;
            for (int i = 1; i <= 4; i++)
                meta_pipe[i] <= '0;
        end else begin
            vld_pipe     <= {vld_pipe[LAT-1:1], de_in};
            vs_pipe      <= {vs_pipe[LAT-1:1], pre_frame_vsync};
            hs_pipe      <= {hs_pipe[LAT-1:1], pre_frame_href};
            x1           <= x_cur;
            meta_pipe[1] <= meta_in;
            for (int i = 2; i <= 4; i++)
                meta_pipe[i] <= meta_pipe[i-1];
        end
    end

    vip_line_buf #(.DEPTH(H_MAX), .AW(AW)) u_lb (
        .clk   (clk),
        .addr  (x1[AW-1:0]),
        .we    (vld_pipe[1] & ~meta_pipe[1].ovf),
        .wdata (meta_pipe[1].luma),
        .rd0   (rd0),
        .rd1   (rd1)
    );

    // win[row][col]: row 0 is y-2, col 2 is the newest column.
    always_ff @(posedge clk) begin
        if (rst) begin
            win <= '0;
        end else if (vld_pipe[2] && !meta_pipe[2].ovf) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= rd1;
            win[1][2] <= rd0;
            win[2][2] <= meta_pipe[2].luma;
        end
    end

    always_comb begin
        sx_p = 10'(win[0][2]) + {1'b0, win[1][2], 1'b0} + 10'(win[2][2]);
        sx_n = 10'(win[0][0]) + {1'b0, win[1][0], 1'b0} + 10'(win[2][0]);
        sy_p = 10'(win[2][0]) + {1'b0, win[2][1], 1'b0} + 10'(win[2][2]);
        sy_n = 10'(win[0][0]) + {1'b0, win[0][1], 1'b0} + 10'(win[0][2]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gx <= '0;
            gy <= '0;
        end else begin
            gx <= $signed({1'b0, sx_p}) - $signed({1'b0, sx_n});
            gy <= $signed({1'b0, sy_p}) - $signed({1'b0, sy_n});
        end
    end

    always_comb begin
        ax  = gx[10] ? 11'(-gx) : 11'(gx);
        ay  = gy[10] ? 11'(-gy) : 11'(gy);
        mag = ax + ay;
        m8  = meta_pipe[4].border ? 8'd0 : ((mag > SAT_MAX) ? 8'(SAT_MAX) : mag[7:0]);
        case (meta_pipe[4].mode)
            MODE_GREY: rgb_c = grey565(meta_pipe[4].luma);
            MODE_MAG:  rgb_c = grey565(m8);
            MODE_BIN:  rgb_c = (m8 > meta_pipe[4].thresh) ? 16'hFFFF : 16'h0000;
            default:   rgb_c = (m8 > meta_pipe[4].thresh) ? 16'h0000 : 16'hFFFF;
        endcase
        if (!vld_pipe[4] || meta_pipe[4].ovf)
            rgb_c = '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            post_rgb <= '0;
        else
            post_rgb <= rgb_c;
    end

    assign post_frame_vsync = vs_pipe[LAT];
    assign post_frame_href  = hs_pipe[LAT];
    assign post_frame_de    = vld_pipe[LAT];

endmodule

// File: tb/tb_vip_sobel_stage.sv
// Directed frames against a frame-image reference model and a LAT-deep scoreboard.
module tb_vip_sobel_stage;

    localparam int H_MAX = 16;
    localparam int X_W   = 11;
    localparam int LAT   = 5;

    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        de;
        logic [15:0] rgb;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     cfg_mode = 2'd0;
    logic [7:0]     cfg_thresh = 8'd0;
    logic           pre_frame_vsync = 1'b0, pre_frame_href = 1'b0, pre_frame_de = 1'b0;
    logic [15:0]    pre_rgb = 16'h0;
    logic           post_frame_vsync, post_frame_href, post_frame_de;
    logic [15:0]    post_rgb;
    logic [X_W-1:0] line_len;
    logic           err_overflow;

    vip_sobel_stage #(.H_MAX(H_MAX), .X_W(X_W), .PIX_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_mode         (cfg_mode),
        .cfg_thresh       (cfg_thresh),
        .pre_frame_vsync  (pre_frame_vsync),
        .pre_frame_href   (pre_frame_href),
        .pre_frame_de     (pre_frame_de),
        .pre_rgb          (pre_rgb),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_de    (post_frame_de),
        .post_rgb         (post_rgb),
        .line_len         (line_len),
        .err_overflow     (err_overflow)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          n_chk = 0, n_pass = 0, n_fail = 0;
    logic [15:0] frm [0:7][0:31];
    logic        m_armed, m_vsd, m_hsd, m_err;
    int          m_x, m_y, m_len;
    logic [1:0]  m_mode;
    logic [7:0]  m_thr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int lum(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        r = r * 8 + r / 4;
        g = g * 4 + g / 16;
        b = b * 8 + b / 4;
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    function automatic logic [15:0] exp_pix(input int x, input int y, input logic [1:0] mode, input logic [7:0] thr);
        int gx, gy, m;
        logic [7:0] g;
        if (x >= H_MAX) return 16'h0000;
        m = 0;
        if (x >= 2 && y >= 2) begin
            gx = lum(frm[y-2][x]) + 2 * lum(frm[y-1][x]) + lum(frm[y][x])
               - lum(frm[y-2][x-2]) - 2 * lum(frm[y-1][x-2]) - lum(frm[y][x-2]);
            gy = lum(frm[y][x-2]) + 2 * lum(frm[y][x-1]) + lum(frm[y][x])
               - lum(frm[y-2][x-2]) - 2 * lum(frm[y-2][x-1]) - lum(frm[y-2][x]);
            m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            if (m > 255) m = 255;
        end
        case (mode)
            2'd0: g = 8'(lum(frm[y][x]));
            2'd1: g = 8'(m);
            2'd2: return (m > int'(thr)) ? 16'hFFFF : 16'h0000;
            default: return (m > int'(thr)) ? 16'h0000 : 16'hFFFF;
        endcase
        return {g[7:3], g[7:2], g[7:3]};
    endfunction

    function automatic logic [15:0] pix_of(input int pat, input int x, input int y);
        case (pat)
            0: return 16'hFFFF;
            1: return (x >= 4) ? 16'hFFFF : 16'h0000;
            2: return (x == 2 && y == 0) ? 16'h02A1 : 16'h0000;
            default: return 16'(x * 2113 + y * 4660 + x * y * 777);
        endcase
    endfunction

    // One input cycle: update the model, queue the expected output, compare after the edge.
    task automatic cyc(input logic vs, input logic hs, input logic de, input logic [15:0] rgb);
        exp_t e;
        logic vrise, hfall;
        vrise = vs & ~m_vsd;
        hfall = m_hsd & ~hs;
        if (vrise) begin
            m_armed = 1'b1; m_mode = cfg_mode; m_thr = cfg_thresh;
            m_x = 0; m_y = 0; m_err = 1'b0;
        end
        e.vs = vs; e.hs = hs; e.de = de & m_armed; e.rgb = 16'h0000;
        if (e.de) begin
            if (m_x < 32 && m_y < 8) frm[m_y][m_x] = rgb;
            e.rgb = exp_pix(m_x, m_y, m_mode, m_thr);
            if (m_x >= H_MAX) m_err = 1'b1;
            if (m_x < 2047) m_x++;
        end else if (hfall) begin
            if (m_x > 0) begin
                m_len = m_x;
                if (m_y < 2047) m_y++;
            end
            m_x = 0;
        end
        m_vsd = vs; m_hsd = hs;
        pre_frame_vsync = vs; pre_frame_href = hs; pre_frame_de = de; pre_rgb = rgb;
        exp_q.push_back(e);
        @(posedge clk); #1;
        check("err_overflow", 32'(err_overflow), 32'(m_err));
        check("line_len", 32'(line_len), 32'(m_len));
        if (exp_q.size() >= LAT) begin
            e = exp_q.pop_front();
            check("post", 32'({post_frame_vsync, post_frame_href, post_frame_de, post_rgb}), 32'(e));
        end
    endtask

    task automatic do_reset(input logic hs);
        rst = 1'b1;
        pre_frame_vsync = 1'b0; pre_frame_href = hs; pre_frame_de = 1'b1; pre_rgb = 16'hFFFF;
        @(posedge clk); #1;
        check("rst_post", 32'({post_frame_vsync, post_frame_href, post_frame_de, post_rgb}), 32'd0);
        check("rst_err", 32'(err_overflow), 32'd0);
        check("rst_len", 32'(line_len), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        repeat (LAT - 1) exp_q.push_back('0);
        m_armed = 1'b0; m_vsd = 1'b0; m_hsd = hs ? 1'b0 : 1'b0; m_err = 1'b0;
        m_x = 0; m_y = 0; m_len = 0; m_mode = 2'd0; m_thr = 8'd0;
    endtask

    task automatic send_frame(input int pat, input int w, input int h, input int rst_row,
                              input int rst_x, input int chg_row, input logic [1:0] chg_mode);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        for (int y = 0; y < h; y++) begin
            if (y == chg_row) cfg_mode = chg_mode;
            for (int x = 0; x < w; x++) begin
                if (y == rst_row && x == rst_x) do_reset(1'b1);
                else cyc(1'b0, 1'b1, 1'b1, pix_of(pat, x, y));
            end
            cyc(1'b0, 1'b0, 1'b0, 16'h0);
            cyc(1'b0, 1'b0, 1'b0, 16'h0);
        end
        repeat (LAT) cyc(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        do_reset(1'b0);
        do_reset(1'b0);
        // pixels before any vsync must not propagate as valid
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 16'hFFFF);
        repeat (LAT) cyc(1'b0, 1'b0, 1'b0, 16'h0);

        cfg_mode = 2'd1; send_frame(0, 8, 4, -1, -1, -1, 2'd0);
        cfg_mode = 2'd0; send_frame(0, 8, 4, -1, -1, -1, 2'd0);
        cfg_mode = 2'd2; cfg_thresh = 8'd100; send_frame(1, 8, 4, -1, -1, -1, 2'd0);
        cfg_mode = 2'd3; send_frame(1, 8, 4, -1, -1, -1, 2'd0);
        cfg_mode = 2'd1; send_frame(3, 8, 4, -1, -1, -1, 2'd0);
        cfg_mode = 2'd0; send_frame(3, 8, 4, -1, -1, -1, 2'd0);

        cfg_mode = 2'd2; cfg_thresh = 8'd100; send_frame(2, 8, 4, -1, -1, -1, 2'd0);
        cfg_thresh = 8'd99; send_frame(2, 8, 4, -1, -1, -1, 2'd0);
        cfg_mode = 2'd1; send_frame(2, 8, 4, -1, -1, -1, 2'd0);

        cfg_thresh = 8'd100;
        cfg_mode = 2'd1; send_frame(1, 8, 4, -1, -1, 1, 2'd2);
        send_frame(1, 8, 4, -1, -1, -1, 2'd0);

        cfg_mode = 2'd0; send_frame(3, 20, 1, -1, -1, -1, 2'd0);
        check("ovf_line_len", 32'(line_len), 32'd20);
        check("ovf_sticky", 32'(err_overflow), 32'd1);
        cfg_mode = 2'd1; send_frame(0, 8, 2, -1, -1, -1, 2'd0);
        check("ovf_cleared", 32'(err_overflow), 32'd0);

        cfg_mode = 2'd2; send_frame(1, 8, 4, 2, 3, -1, 2'd0);
        send_frame(1, 8, 4, -1, -1, -1, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
